// File: rtl/lag_pl_input_buffer_pkg.sv
// Shared types for the receive-side per-PL input buffer.
//   flit_t       : one flit on the link
//   pl_t         : physical-lane index
//   chan_cntrl_t : reverse-channel control word; credits[i] pulses once per
//                  flit dequeued from PL i
//   clogb2       : ceil(log2(value)), minimum 1, for pointer/counter widths
package lag_pl_input_buffer_pkg;

  localparam int unsigned FLIT_WIDTH = 64;
  localparam int unsigned MAX_PLS    = 8;

  typedef logic [FLIT_WIDTH-1:0]      flit_t;
  typedef logic [$clog2(MAX_PLS)-1:0] pl_t;

  typedef struct packed {
    logic [MAX_PLS-1:0] credits;
    logic [3:0]         vc_id;
    logic               link_up;
  } chan_cntrl_t;

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = value - 1;
    while (v != 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/lag_pl_input_buffer_if.sv
// Bundle between the link receiver / router input stage and the buffer.
//   master : drives flit_in, flit_valid_in, deq; observes the rest
//   slave  : the buffer itself
interface lag_pl_input_buffer_if
  import lag_pl_input_buffer_pkg::*;
#(
  parameter int unsigned num_pls    = 4,
  parameter int unsigned flit_width = FLIT_WIDTH,
  parameter int unsigned occ_bits   = 3
);
  logic [flit_width-1:0]               flit_in;
  logic [num_pls-1:0]                  flit_valid_in;
  logic [num_pls-1:0]                  deq;
  logic [num_pls-1:0][flit_width-1:0]  head_flit;
  logic [num_pls-1:0]                  head_valid;
  chan_cntrl_t                         channel_cntrl_out;
  logic [num_pls-1:0][occ_bits-1:0]    pl_occupancy;
  logic [num_pls-1:0]                  overflow_err;

  modport master (
    output flit_in, flit_valid_in, deq,
    input  head_flit, head_valid, channel_cntrl_out, pl_occupancy, overflow_err
  );

  modport slave (
    input  flit_in, flit_valid_in, deq,
    output head_flit, head_valid, channel_cntrl_out, pl_occupancy, overflow_err
  );
endinterface

// File: rtl/lag_pl_fifo.sv
// Single-PL circular FIFO with registered credit pulse and sticky overflow.
//   flit_i/wr_i    : enqueue request (already qualified by the one-hot check)
//   viol_i         : external protocol violation for this PL (multi-hot)
//   deq_i          : consumer pops the head
//   head_flit_o    : entry at rd_ptr (combinational mux of storage)
//   head_valid_o   : FIFO non-empty
//   occ_o          : stored entries
//   credit_o       : one-cycle pulse the cycle after each effective dequeue
//   overflow_err_o : sticky until reset
module lag_pl_fifo #(
  parameter int unsigned depth    = 4,
  parameter int unsigned width    = 64,
  parameter int unsigned ptr_bits = 2,
  parameter int unsigned occ_bits = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] flit_i,
  input  logic             wr_i,
  input  logic             viol_i,
  input  logic             deq_i,
  output logic [width-1:0] head_flit_o,
  output logic             head_valid_o,
  output logic [occ_bits-1:0] occ_o,
  output logic             credit_o,
  output logic             overflow_err_o
);

  localparam logic [ptr_bits-1:0] PTR_LAST = ptr_bits'(depth - 1);
  localparam logic [occ_bits-1:0] OCC_FULL = occ_bits'(depth);

  logic [width-1:0]    mem_q [depth];
  logic [ptr_bits-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_bits-1:0] rd_ptr_q, rd_ptr_d;
  logic [occ_bits-1:0] occ_q, occ_d;
  logic                credit_q, credit_d;
  logic                ovf_q, ovf_d;
  logic                full, empty, do_enq, do_deq;

  assign full   = (occ_q == OCC_FULL);
  assign empty  = (occ_q == '0);
  // A write into a full FIFO is a violation even when a pop frees a slot
  // in the same cycle, so the enqueue qualifier looks only at occ_q.
  assign do_enq = wr_i & ~full;
  assign do_deq = deq_i & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_enq) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + ptr_bits'(1);
    if (do_deq) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + ptr_bits'(1);
    case ({do_enq, do_deq})
      2'b10:   occ_d = occ_q + occ_bits'(1);
      2'b01:   occ_d = occ_q - occ_bits'(1);
      default: occ_d = occ_q;
    endcase
    credit_d = do_deq;
    ovf_d    = ovf_q | viol_i | (wr_i & full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: head_valid gates its use.
  always_ff @(posedge clk) begin
    if (do_enq) mem_q[wr_ptr_q] <= flit_i;
  end

  assign head_flit_o    = mem_q[rd_ptr_q];
  assign head_valid_o   = ~empty;
  assign occ_o          = occ_q;
  assign credit_o       = credit_q;
  assign overflow_err_o = ovf_q;

endmodule

// File: rtl/lag_pl_input_buffer.sv
// Receive-side per-PL input buffer with credit return.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of lag_pl_input_buffer_if (flit in, dequeue,
//                head flits, occupancy, credits, overflow flags)
// One lag_pl_fifo per PL; this level fans out flit_in, rejects multi-hot
// flit_valid_in and packs the credit pulses into channel_cntrl_out.
module lag_pl_input_buffer
  import lag_pl_input_buffer_pkg::*;
#(
  parameter int unsigned num_pls    = 4,
  parameter int unsigned buf_depth  = 4,
  parameter int unsigned flit_width = FLIT_WIDTH,
  parameter int unsigned ptr_bits   = clogb2(buf_depth),
  parameter int unsigned occ_bits   = clogb2(buf_depth + 1)
) (
  input logic                  clk,
  input logic                  rst_n,
  lag_pl_input_buffer_if.slave bus
);

  logic [num_pls-1:0]                 valid_in;
  logic                               multi_hot;
  logic [num_pls-1:0][flit_width-1:0] head_flit;
  logic [num_pls-1:0]                 head_valid;
  logic [num_pls-1:0][occ_bits-1:0]   occ;
  logic [num_pls-1:0]                 credits;
  logic [num_pls-1:0]                 ovf;
  chan_cntrl_t                        cc;

  assign valid_in  = bus.flit_valid_in;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_hot = |(valid_in & (valid_in - num_pls'(1)));

  for (genvar g = 0; g < num_pls; g++) begin : g_pl
    lag_pl_fifo #(
      .depth    (buf_depth),
      .width    (flit_width),
      .ptr_bits (ptr_bits),
      .occ_bits (occ_bits)
    ) u_fifo (
      .clk            (clk),
      .rst_n          (rst_n),
      .flit_i         (bus.flit_in),
      .wr_i           (valid_in[g] & ~multi_hot),
      .viol_i         (valid_in[g] & multi_hot),
      .deq_i          (bus.deq[g]),
      .head_flit_o    (head_flit[g]),
      .head_valid_o   (head_valid[g]),
      .occ_o          (occ[g]),
      .credit_o       (credits[g]),
      .overflow_err_o (ovf[g])
    );
  end

  always_comb begin
    cc = '0;
    cc.credits[num_pls-1:0] = credits;
  end

  assign bus.head_flit         = head_flit;
  assign bus.head_valid        = head_valid;
  assign bus.pl_occupancy      = occ;
  assign bus.overflow_err      = ovf;
  assign bus.channel_cntrl_out = cc;

endmodule

// File: tb/tb_lag_pl_input_buffer.sv
module tb_lag_pl_input_buffer;
  import lag_pl_input_buffer_pkg::*;

  localparam int unsigned OCC_A = clogb2(4 + 1);
  localparam int unsigned OCC_B = clogb2(3 + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lag_pl_input_buffer_if #(.num_pls(4), .flit_width(64), .occ_bits(OCC_A)) ifa ();
  lag_pl_input_buffer_if #(.num_pls(4), .flit_width(64), .occ_bits(OCC_B)) ifb ();

  lag_pl_input_buffer #(.num_pls(4), .buf_depth(4), .flit_width(64)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  lag_pl_input_buffer #(.num_pls(4), .buf_depth(3), .flit_width(64)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-instance, per-PL queue of stored flits.
  logic [63:0] mq [2][4][$];
  bit          err_m  [2][4];
  bit          cred_m [2][4];
  int          dep    [2] = '{4, 3};

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        mq[k][i].delete();
        err_m[k][i]  = 1'b0;
        cred_m[k][i] = 1'b0;
      end
  endtask

  task automatic compare_all(input string ph);
    logic        hv, er, cr;
    logic [63:0] hf;
    logic [2:0]  oc;
    logic [4:0]  other;
    for (int k = 0; k < 2; k++) begin
      other = (k == 0) ? {ifa.channel_cntrl_out.vc_id, ifa.channel_cntrl_out.link_up}
                       : {ifb.channel_cntrl_out.vc_id, ifb.channel_cntrl_out.link_up};
      check_eq($sformatf("%s k%0d cc_other", ph, k), 64'(other), 64'd0);
      for (int i = 0; i < 4; i++) begin
        if (k == 0) begin
          hv = ifa.head_valid[i];  hf = ifa.head_flit[i];  oc = 3'(ifa.pl_occupancy[i]);
          er = ifa.overflow_err[i]; cr = ifa.channel_cntrl_out.credits[i];
        end else begin
          hv = ifb.head_valid[i];  hf = ifb.head_flit[i];  oc = 3'(ifb.pl_occupancy[i]);
          er = ifb.overflow_err[i]; cr = ifb.channel_cntrl_out.credits[i];
        end
        check_eq($sformatf("%s k%0d pl%0d head_valid", ph, k, i), 64'(hv), 64'(mq[k][i].size() != 0));
        check_eq($sformatf("%s k%0d pl%0d occ", ph, k, i), 64'(oc), 64'(mq[k][i].size()));
        check_eq($sformatf("%s k%0d pl%0d ovf", ph, k, i), 64'(er), 64'(err_m[k][i]));
        check_eq($sformatf("%s k%0d pl%0d credit", ph, k, i), 64'(cr), 64'(cred_m[k][i]));
        if (mq[k][i].size() != 0)
          check_eq($sformatf("%s k%0d pl%0d head", ph, k, i), hf, mq[k][i][0]);
      end
    end
  endtask

  // Called at posedge+1: drive, compare at the falling edge, advance model,
  // then move to the next posedge+1.
  task automatic step(input string ph, input logic [3:0] v, input logic [63:0] d,
                      input logic [3:0] dq);
    bit multi;
    bit full;
    bit empty;
    multi = ((v & (v - 4'd1)) != 4'd0);
    ifa.flit_in = d; ifa.flit_valid_in = v; ifa.deq = dq;
    ifb.flit_in = d; ifb.flit_valid_in = v; ifb.deq = dq;
    #4;
    compare_all(ph);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        full  = (mq[k][i].size() == dep[k]);
        empty = (mq[k][i].size() == 0);
        if (v[i] && (multi || full)) err_m[k][i] = 1'b1;
        cred_m[k][i] = dq[i] && !empty;
        if (dq[i] && !empty) void'(mq[k][i].pop_front());
        if (v[i] && !multi && !full) mq[k][i].push_back(d);
      end
    @(posedge clk);
    #1;
  endtask

  initial begin
    ifa.flit_in = '0; ifa.flit_valid_in = '0; ifa.deq = '0;
    ifb.flit_in = '0; ifb.flit_valid_in = '0; ifb.deq = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle after reset
    repeat (2) step("idle", 4'b0000, 64'd0, 4'b0000);

    // Four flits to PL2, then four back-to-back dequeues
    for (int j = 0; j < 4; j++) step("pl2_wr", 4'b0100, 64'hA0 + 64'(j), 4'b0000);
    for (int j = 0; j < 4; j++) step("pl2_deq", 4'b0000, 64'd0, 4'b0100);
    repeat (2) step("pl2_idle", 4'b0000, 64'd0, 4'b0000);

    // Fill PL0, then a write into a full FIFO with a same-cycle dequeue
    for (int j = 0; j < 4; j++) step("pl0_fill", 4'b0001, 64'h10 + 64'(j), 4'b0000);
    step("pl0_ovf", 4'b0001, 64'h14, 4'b0001);
    step("pl0_after", 4'b0000, 64'd0, 4'b0000);
    for (int j = 0; j < 4; j++) step("pl0_drain", 4'b0000, 64'd0, 4'b0001);
    step("pl0_idle", 4'b0000, 64'd0, 4'b0000);

    // Streaming on PL1: simultaneous enqueue/dequeue, pointers wrap
    for (int j = 0; j < 2; j++) step("pl1_pre", 4'b0010, 64'h20 + 64'(j), 4'b0000);
    for (int j = 0; j < 10; j++) step("pl1_stream", 4'b0010, 64'h30 + 64'(j), 4'b0010);
    for (int j = 0; j < 2; j++) step("pl1_drain", 4'b0000, 64'd0, 4'b0010);
    step("pl1_idle", 4'b0000, 64'd0, 4'b0000);

    // PL3 at occ 2 with a credit pending, then asynchronous reset
    for (int j = 0; j < 3; j++) step("pl3_fill", 4'b1000, 64'h50 + 64'(j), 4'b0000);
    step("pl3_deq", 4'b0000, 64'd0, 4'b1000);
    check_eq("pre_rst credit3", 64'(ifa.channel_cntrl_out.credits[3]), 64'(cred_m[0][3]));
    check_eq("pre_rst occ3", 64'(ifa.pl_occupancy[3]), 64'(mq[0][3].size()));
    rst_n = 1'b0;
    ifa.flit_valid_in = '0; ifa.deq = '0;
    ifb.flit_valid_in = '0; ifb.deq = '0;
    #1;
    check_eq("rst credits_a", 64'(ifa.channel_cntrl_out.credits), 64'd0);
    check_eq("rst credits_b", 64'(ifb.channel_cntrl_out.credits), 64'd0);
    check_eq("rst head_valid_a", 64'(ifa.head_valid), 64'd0);
    check_eq("rst head_valid_b", 64'(ifb.head_valid), 64'd0);
    check_eq("rst occ_a", 64'(ifa.pl_occupancy), 64'd0);
    check_eq("rst occ_b", 64'(ifb.pl_occupancy), 64'd0);
    check_eq("rst ovf_a", 64'(ifa.overflow_err), 64'd0);
    check_eq("rst ovf_b", 64'(ifb.overflow_err), 64'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First write/deq pair after reset
    step("post_rst_wr", 4'b0100, 64'hA0, 4'b0000);
    step("post_rst_deq", 4'b0000, 64'd0, 4'b0100);
    repeat (2) step("post_rst_idle", 4'b0000, 64'd0, 4'b0000);

    // Dequeue on an empty PL, then a multi-hot write
    step("deq_empty", 4'b0000, 64'd0, 4'b0010);
    step("deq_empty_after", 4'b0000, 64'd0, 4'b0000);
    step("multi_hot", 4'b0101, 64'h77, 4'b0000);
    repeat (2) step("multi_after", 4'b0000, 64'd0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
